// File: rtl/decoder_pkg.sv
// Shared widths, FSM state type and code-to-strobe helper for the strobe decoder.
package decoder_pkg;

   localparam int unsigned CODE_W   = 4;
   localparam int unsigned ONEHOT_W = 16;
   localparam int unsigned CNT_W    = 8;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      GAP
   } strobe_state_t;

   // Binary code to one-hot select line.
   function automatic logic [ONEHOT_W-1:0] onehot16(input logic [CODE_W-1:0] code);
      return ONEHOT_W'(1) << code;
   endfunction

endpackage

// File: rtl/decoder_4_by_16_strobe_counter.sv
// strobe_counter: 8-bit load/decrement counter with a zero flag.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   load          load load_val this cycle (has priority over dec)
//   load_val      value to load
//   dec           decrement by one; saturates at zero
//   zero_c        combinational flag, counter value is zero
module strobe_counter
   import decoder_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_c
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count; the zero guard keeps the count from ever wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/decoder_4_by_16_strobe.sv
// decoder_4_by_16_strobe: registered 4-to-16 one-hot decoder with valid/ready
// input. Each accepted code drives a one-hot strobe for PULSE_LEN cycles,
// followed by GAP_LEN all-zero cycles before the next code can be accepted.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   in_valid     data_in holds a code
//   in_ready     code can be accepted this cycle (state and flush only)
//   data_in      4-bit binary code
//   flush        abort current strobe/gap, return to IDLE
//   data_out     registered one-hot strobe
//   out_valid    high exactly while data_out is non-zero
//   busy         FSM is not in IDLE
module decoder_4_by_16_strobe
   import decoder_pkg::*;
#(
   parameter int unsigned PULSE_LEN = 1,
   parameter int unsigned GAP_LEN   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CODE_W-1:0]   data_in,
   input  logic                flush,
   output logic [ONEHOT_W-1:0] data_out,
   output logic                out_valid,
   output logic                busy
);

   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);
   localparam logic             HAS_GAP    = (GAP_LEN > 0);

   strobe_state_t         state_q, state_d;
   logic [ONEHOT_W-1:0]   data_out_q, data_out_d;
   logic                  out_valid_q, out_valid_d;
   logic                  cnt_load, cnt_dec, cnt_zero_c;
   logic [CNT_W-1:0]      cnt_load_val;

   strobe_counter u_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero_c   (cnt_zero_c)
   );

   // Next-state and strobe register inputs.
   always_comb begin
      state_d      = state_q;
      data_out_d   = data_out_q;
      out_valid_d  = out_valid_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;

      unique case (state_q)
         IDLE: begin
            // flush blocks acceptance, so transfer == in_valid & ~flush here.
            if (in_valid && !flush) begin
               data_out_d   = onehot16(data_in);
               out_valid_d  = 1'b1;
               cnt_load     = 1'b1;
               cnt_load_val = PULSE_LOAD;
               state_d      = DRIVE;
            end
         end
         DRIVE: begin
            if (flush) begin
               data_out_d  = '0;
               out_valid_d = 1'b0;
               cnt_load    = 1'b1;
               state_d     = IDLE;
            end else if (cnt_zero_c) begin
               data_out_d  = '0;
               out_valid_d = 1'b0;
               if (HAS_GAP) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = GAP_LOAD;
                  state_d      = GAP;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         GAP: begin
            if (flush) begin
               cnt_load = 1'b1;
               state_d  = IDLE;
            end else if (cnt_zero_c) begin
               state_d = IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !flush;
   assign busy      = (state_q != IDLE);
   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;

endmodule
